// File: rtl/spi_mdv_buffer.sv
// rtl/spi_mdv_buffer.sv - Microdrive sector buffer between the QL microdrive emulation and the ESP32 SPI slave
// Ports:
//   clk, reset                              single clock, synchronous active-high reset
//   spi_rd, spi_wr, spi_addr, spi_wdata     SPI BRAM bus from the ESP32 slave (buffer window / control window)
//   spi_rdata                               registered read data back to the slave
//   req_valid, req_type, req_ready          sector request from the QL side
//   mdv_req, mdv_req_type                   request pulse and latched type toward the ESP32
//   byte_valid, byte_data, byte_last,
//   byte_ready                              committed sector bytes streamed to the QL side
//   err                                     1-clk pulse on FILL timeout or bad commit length
module spi_mdv_buffer #(
  parameter logic [7:0] c_addr_buf     = 8'hD0,
  parameter logic [7:0] c_addr_ctl     = 8'hD2,
  parameter int         c_addr_bits    = 32,
  parameter int         c_buf_bits     = 10,
  parameter int         c_req_cycles   = 4,
  parameter int         c_timeout_bits = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spi_rd,
  input  logic                   spi_wr,
  input  logic [c_addr_bits-1:0] spi_addr,
  input  logic [7:0]             spi_wdata,
  output logic [7:0]             spi_rdata,
  input  logic                   req_valid,
  input  logic [7:0]             req_type,
  output logic                   req_ready,
  output logic                   mdv_req,
  output logic [7:0]             mdv_req_type,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  output logic                   byte_last,
  input  logic                   byte_ready,
  output logic                   err
);
  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_req    = 2'd1,
    st_fill   = 2'd2,
    st_stream = 2'd3
  } state_t;

  localparam int            lw      = c_buf_bits + 1;
  localparam int            rcw     = $clog2(c_req_cycles + 1);
  localparam logic [lw-1:0] max_len = lw'(2 ** c_buf_bits);

  state_t state, next_state;

  logic [7:0] mem [0:(2**c_buf_bits)-1];
  logic [7:0] mem_a_q, mem_b_q;

  logic [rcw-1:0]            req_cnt;
  logic [c_timeout_bits-1:0] tmo_cnt;
  logic [lw-1:0]             len_q, rd_ptr;
  logic                      rd_v, rd_last;
  logic                      skid_v, skid_last;
  logic [7:0]                skid_d;
  logic                      err_set, err_sticky, start_stream;
  logic                      sel_buf_q, sel_ctl_q, rd_ctl_q;
  logic [7:0]                ctl_q;

  logic                  buf_hit, ctl_hit, buf_wr, commit, len_ok;
  logic                  pop, out_free, issue, issue_last;
  logic [lw-1:0]         commit_len;
  logic [c_buf_bits-1:0] buf_off;
  logic [1:0]            occ;
  logic [7:0]            status;
  logic                  unused_addr;

  assign buf_hit    = spi_addr[c_addr_bits-1 -: 8] == c_addr_buf;
  assign ctl_hit    = spi_addr[c_addr_bits-1 -: 8] == c_addr_ctl;
  assign buf_off    = spi_addr[c_buf_bits-1:0];
  assign commit_len = spi_addr[c_buf_bits:0];
  assign buf_wr     = spi_wr && buf_hit && (state == st_fill);
  assign commit     = spi_wr && ctl_hit && (state == st_fill);
  assign len_ok     = (commit_len != '0) && (commit_len <= max_len);
  assign unused_addr = ^spi_addr[c_addr_bits-9:lw];

  // Stream pipeline: BRAM read stage (rd_v) -> skid register -> output register.
  // A read is only issued when both storage slots can absorb it, so the stream
  // never drops a byte and still sustains one byte per clock with byte_ready high.
  assign pop      = byte_valid && byte_ready;
  assign out_free = !byte_valid || byte_ready;
  assign occ      = 2'(byte_valid) + 2'(skid_v) + 2'(rd_v) - 2'(pop);
  // Byte 0 is read in the commit cycle itself so it is valid 2 clks after the commit strobe.
  assign issue      = start_stream || ((state == st_stream) && (rd_ptr != len_q) && (occ < 2'd2));
  assign issue_last = start_stream ? (commit_len == lw'(1)) : (rd_ptr == len_q - lw'(1));

  assign status    = {state != st_idle, err_sticky, 4'b0000, state};
  assign spi_rdata = sel_buf_q ? mem_a_q : (sel_ctl_q ? ctl_q : 8'h00);

  always_ff @(posedge clk) begin
    if (reset) state <= st_idle;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    mdv_req      = 1'b0;
    err_set      = 1'b0;
    start_stream = 1'b0;
    case (state)
      st_idle: begin
        req_ready = 1'b1;
        if (req_valid) next_state = st_req;
      end
      st_req: begin
        mdv_req = 1'b1;
        if (req_cnt == rcw'(c_req_cycles - 1)) next_state = st_fill;
      end
      st_fill: begin
        if (commit) begin
          if (len_ok) begin
            start_stream = 1'b1;
            next_state   = st_stream;
          end else begin
            err_set    = 1'b1;
            next_state = st_idle;
          end
        end else if (!buf_wr && (&tmo_cnt)) begin
          err_set    = 1'b1;
          next_state = st_idle;
        end
      end
      default: begin
        if (pop && byte_last) next_state = st_idle;
      end
    endcase
  end

  // True dual port buffer: port A serves the SPI side, port B feeds the stream.
  always_ff @(posedge clk) begin
    if (buf_wr) mem[buf_off] <= spi_wdata;
    mem_a_q <= mem[buf_off];
    mem_b_q <= mem[rd_ptr[c_buf_bits-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_cnt      <= '0;
      tmo_cnt      <= '0;
      mdv_req_type <= 8'h00;
      err          <= 1'b0;
      err_sticky   <= 1'b0;
      len_q        <= '0;
      rd_ptr       <= '0;
      rd_v         <= 1'b0;
      rd_last      <= 1'b0;
      skid_v       <= 1'b0;
      skid_last    <= 1'b0;
      skid_d       <= 8'h00;
      byte_valid   <= 1'b0;
      byte_data    <= 8'h00;
      byte_last    <= 1'b0;
      sel_buf_q    <= 1'b0;
      sel_ctl_q    <= 1'b0;
      rd_ctl_q     <= 1'b0;
      ctl_q        <= 8'h00;
    end else begin
      req_cnt <= (state == st_req) ? req_cnt + rcw'(1) : '0;
      // Any buffer write restarts the FILL timeout.
      tmo_cnt <= ((state == st_fill) && !buf_wr) ? tmo_cnt + c_timeout_bits'(1) : '0;
      if ((state == st_idle) && req_valid) mdv_req_type <= req_type;

      err <= err_set;
      if (err_set)                  err_sticky <= 1'b1;
      else if (rd_ctl_q && !spi_rd) err_sticky <= 1'b0;

      if (start_stream) len_q <= commit_len;
      if (issue)                   rd_ptr <= rd_ptr + lw'(1);
      else if (state != st_stream) rd_ptr <= '0;
      rd_v <= issue;
      if (issue) rd_last <= issue_last;

      if (state == st_stream) begin
        if (out_free) begin
          if (skid_v) begin
            byte_valid <= 1'b1;
            byte_data  <= skid_d;
            byte_last  <= skid_last;
            skid_v     <= rd_v;
            skid_d     <= mem_b_q;
            skid_last  <= rd_last;
          end else if (rd_v) begin
            byte_valid <= 1'b1;
            byte_data  <= mem_b_q;
            byte_last  <= rd_last;
          end else begin
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
          end
        end else if (rd_v) begin
          skid_v    <= 1'b1;
          skid_d    <= mem_b_q;
          skid_last <= rd_last;
        end
      end else begin
        byte_valid <= 1'b0;
        byte_last  <= 1'b0;
        skid_v     <= 1'b0;
      end

      sel_buf_q <= buf_hit;
      sel_ctl_q <= ctl_hit;
      rd_ctl_q  <= spi_rd && ctl_hit;
      ctl_q     <= status;
    end
  end
endmodule

// File: tb/tb_spi_mdv_buffer.sv
// tb/tb_spi_mdv_buffer.sv - Self-checking bench for spi_mdv_buffer with a queue-based sector model
module tb_spi_mdv_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_rd = 1'b0;
  logic        spi_wr = 1'b0;
  logic [31:0] spi_addr = 32'h0;
  logic [7:0]  spi_wdata = 8'h00;
  logic [7:0]  spi_rdata;
  logic        req_valid = 1'b0;
  logic [7:0]  req_type = 8'h00;
  logic        req_ready;
  logic        mdv_req;
  logic [7:0]  mdv_req_type;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready = 1'b0;
  logic        err;

  spi_mdv_buffer #(.c_timeout_bits(8)) dut (
    .clk(clk), .reset(reset),
    .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .req_valid(req_valid), .req_type(req_type), .req_ready(req_ready),
    .mdv_req(mdv_req), .mdv_req_type(mdv_req_type),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model_mem [0:1023];
  logic [7:0]  exp_q [$];
  int          hs_count = 0;
  logic [7:0]  last_hs_data = 8'h00;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic [7:0]  cmp_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every handshake is matched against the expected sector bytes; a stalled byte must not move.
  initial begin : compare
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", byte_valid, 1);
          check("stall_data", byte_data, prev_data);
          check("stall_last", byte_last, prev_last);
        end
        if (byte_valid) begin
          check("stream_extra", exp_q.size() != 0, 1);
          if (byte_ready && exp_q.size() != 0) begin
            cmp_e = exp_q.pop_front();
            check("stream_data", byte_data, cmp_e);
            check("stream_last", byte_last, exp_q.size() == 0);
            hs_count++;
            last_hs_data = byte_data;
          end
        end
        prev_stall = byte_valid && !byte_ready;
        prev_data  = byte_data;
        prev_last  = byte_last;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_write(input logic [31:0] a, input logic [7:0] d);
    spi_addr = a; spi_wdata = d; spi_wr = 1'b1;
    tick();
    spi_wr = 1'b0;
  endtask

  task automatic spi_read(input logic [31:0] a, output logic [7:0] d);
    spi_addr = a; spi_rd = 1'b1;
    tick();
    d = spi_rdata;
    spi_rd = 1'b0;
    tick();
  endtask

  // Leaves the block 4 clks into FILL.
  task automatic do_req(input logic [7:0] t);
    int hi = 0;
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_type = t;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mdv_req) hi++;
      check("req_ready_busy", req_ready, 0);
      tick();
    end
    check("mdv_req_len", hi, 4);
    check("mdv_req_type", mdv_req_type, t);
  endtask

  task automatic fill(input int len, input bit counting);
    logic [7:0]  d;
    logic [13:0] hi;
    for (int i = 0; i < len; i++) begin
      d  = counting ? 8'(i) : 8'($urandom);
      hi = counting ? 14'd0 : 14'($urandom);
      model_mem[i] = d;
      spi_write({8'hD0, hi, 10'(i)}, d);
    end
  endtask

  task automatic commit(input int len);
    hs_count = 0;
    for (int i = 0; i < len; i++) exp_q.push_back(model_mem[i]);
    spi_write(32'hD2000000 | 32'(len), 8'($urandom));
  endtask

  task automatic drain(input int mode, input int len, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 8 * len + 20) begin
      case (mode)
        0:       byte_ready = 1'b1;
        1:       byte_ready = ~byte_ready;
        default: byte_ready = 1'($urandom);
      endcase
      tick();
      n++;
    end
    check("stream_done", exp_q.size(), 0);
    exp_q.delete();
    check("stream_count", hs_count, len);
    check("idle_after_stream", req_ready, 1);
  endtask

  task automatic commit_and_stream(input int len, input int mode);
    int n;
    byte_ready = (mode == 2) ? 1'($urandom) : 1'b1;
    commit(len);
    check("first_valid_early", byte_valid, 0);
    tick();
    check("first_valid", byte_valid, 1);
    drain(mode, len, n);
    if (mode == 0) check("stream_rate", n, len);
  endtask

  initial begin : main
    logic [7:0] d;
    int n, w, len, mode, off;
    logic [7:0] t;

    tick(); tick();
    reset = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_mdv_req", mdv_req, 0);
    check("rst_mdv_req_type", mdv_req_type, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_last", byte_last, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_err", err, 0);
    check("rst_spi_rdata", spi_rdata, 0);

    // Request, ignored second request, counting sector streamed at full rate.
    do_req(8'h02);
    req_valid = 1'b1; req_type = 8'h77;
    tick();
    req_valid = 1'b0;
    check("ignored_req_pulse", mdv_req, 0);
    check("ignored_req_type", mdv_req_type, 8'h02);
    fill(16, 1'b1);
    commit_and_stream(16, 0);
    check("last_byte_value", last_hs_data, 8'h0F);
    spi_read(32'hD000000A, d);
    check("buf_readback", d, 8'h0A);

    // Same sector with byte_ready toggling.
    do_req(8'h03);
    fill(16, 1'b1);
    commit_and_stream(16, 1);
    check("toggle_last_value", last_hs_data, 8'h0F);

    // Commit and buffer write outside FILL are ignored.
    spi_write(32'hD2000010, 8'h00);
    tick();
    check("idle_commit_ready", req_ready, 1);
    check("idle_commit_valid", byte_valid, 0);
    spi_write(32'hD0000000, 8'hEE);
    spi_read(32'hD0000000, d);
    check("idle_write_ignored", d, 8'h00);

    // Zero-length commit.
    do_req(8'h01);
    spi_write(32'hD2000000, 8'h00);
    check("zero_err_pulse", err, 1);
    check("zero_idle", req_ready, 1);
    tick();
    check("zero_err_end", err, 0);
    spi_read(32'hD2000000, d);
    check("ctl_sticky", d, 8'h40);
    spi_read(32'hD2000000, d);
    check("ctl_cleared", d, 8'h00);

    // Oversized commit length.
    do_req(8'h01);
    spi_write(32'hD2000000 | 32'($urandom_range(1025, 2047)), 8'h00);
    check("big_err_pulse", err, 1);
    spi_read(32'hD2000000, d);
    check("big_ctl_sticky", d, 8'h40);

    // Timeout with no buffer activity: err 256 clks after FILL entry.
    do_req(8'h05);
    n = 0;
    while (!err && n < 400) begin tick(); n++; end
    check("timeout_cycles", n, 252);
    check("timeout_idle", req_ready, 1);
    tick();
    check("timeout_err_end", err, 0);
    spi_read(32'hD2000000, d);
    check("timeout_ctl", d, 8'h40);

    // A buffer write restarts the timeout.
    do_req(8'h06);
    w = $urandom_range(10, 50);
    repeat (w) tick();
    spi_write(32'hD0000005, 8'h5A);
    model_mem[5] = 8'h5A;
    n = 0;
    while (!err && n < 400) begin tick(); n++; end
    check("timeout_restart", n, 256);
    spi_read(32'hD2000000, d);
    check("timeout_restart_ctl", d, 8'h40);

    // Buffer locked during STREAM; SPI reads share the buffer.
    do_req(8'h10);
    fill(8, 1'b0);
    byte_ready = 1'b0;
    commit(8);
    tick(); tick();
    check("locked_valid", byte_valid, 1);
    spi_write(32'hD0000000, ~model_mem[0]);
    spi_read(32'hD2000000, d);
    check("ctl_stream", d, 8'h83);
    spi_read(32'hD0000003, d);
    check("dual_port_read", d, model_mem[3]);
    drain(0, 8, n);
    spi_read(32'hD0000000, d);
    check("locked_write", d, model_mem[0]);

    // Reset in the middle of a stream.
    do_req(8'h11);
    fill(8, 1'b0);
    byte_ready = 1'b0;
    commit(8);
    tick(); tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_valid", byte_valid, 0);
    check("midrst_mdv_req", mdv_req, 0);
    reset = 1'b0;
    check("midrst_ready", req_ready, 1);
    tick();

    // Randomised sectors.
    for (int it = 0; it < 8; it++) begin
      len  = $urandom_range(1, 64);
      mode = $urandom_range(0, 2);
      t    = 8'($urandom);
      do_req(t);
      fill(len, 1'b0);
      commit_and_stream(len, mode);
      off = $urandom_range(0, len - 1);
      spi_read({8'hD0, 14'($urandom), 10'(off)}, d);
      check("rand_readback", d, model_mem[off]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
